// File: rtl/x_mem_pkg.sv
// Shared x_mem geometry, element/index types and the reader's state encoding.
package x_mem_pkg;

  localparam int X_MEM_HEIGHT  = 64;
  localparam int ELEMENT_WIDTH = 32;
  localparam int INDEX_WIDTH   = $clog2(X_MEM_HEIGHT);

  typedef logic [ELEMENT_WIDTH-1:0] element_t;
  typedef logic [INDEX_WIDTH-1:0]   index_t;
  // Packed so element i occupies [ELEMENT_WIDTH*i +: ELEMENT_WIDTH] of the flat bus.
  typedef element_t [X_MEM_HEIGHT-1:0] vector_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    STREAM = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam index_t LAST_INDEX = index_t'(X_MEM_HEIGHT - 1);

  function automatic logic is_last(input index_t idx);
    return (idx == LAST_INDEX);
  endfunction

endpackage

// File: rtl/x_vec_reader_if.sv
// x_mem read port plus element stream; master = reader, slave = memory/downstream side.
interface x_vec_reader_if;
  import x_mem_pkg::*;

  logic     mem_read;
  logic     mem_write;
  logic     mem_finish;
  vector_t  mem_data;
  logic     out_valid;
  logic     out_ready;
  element_t out_data;
  index_t   out_index;
  logic     out_last;

  modport master (
    output mem_read, mem_write,
    input  mem_finish, mem_data,
    output out_valid, out_data, out_index, out_last,
    input  out_ready
  );

  modport slave (
    input  mem_read, mem_write,
    output mem_finish, mem_data,
    input  out_valid, out_data, out_index, out_last,
    output out_ready
  );

endinterface

// File: rtl/x_vec_shadow.sv
// Frozen copy of the x_mem vector with an element-select mux.
module x_vec_shadow
  import x_mem_pkg::*;
(
  input  logic     clk,
  input  logic     load,
  input  vector_t  load_data,
  input  index_t   sel,
  output element_t elem
);

  vector_t shadow_r;

  // Capture register; deliberately not reset so the last vector survives rst
  always_ff @(posedge clk) begin
    if (load) begin
      shadow_r <= load_data;
    end
  end

  assign elem = shadow_r[sel];

endmodule

// File: rtl/x_vec_reader.sv
// Read-side initiator for x_mem: read strobe, one-cycle capture, indexed element stream.
// Optional WAIT timeout with err flag is enabled by defining X_READ_TIMEOUT_EN.
module x_vec_reader
  import x_mem_pkg::*;
`ifdef X_READ_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = 1024
)
`endif
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           err,
  x_vec_reader_if.master bus
);

  state_t   state_r;
  index_t   index_r;
  element_t out_data_r;
  logic     busy_r;
  logic     done_r;
  logic     mem_read_r;
  logic     out_valid_r;
  logic     out_last_r;

  index_t   idx_inc_s;
  element_t next_elem_s;
  logic     capture_s;
  logic     timeout_s;

  assign idx_inc_s = index_r + index_t'(1);
  assign capture_s = (state_r == WAIT) && bus.mem_finish;

  // The mux looks one element ahead so out_data can be registered on each accepted beat.
  x_vec_shadow u_shadow (
    .clk       (clk),
    .load      (capture_s),
    .load_data (bus.mem_data),
    .sel       (idx_inc_s),
    .elem      (next_elem_s)
  );

`ifdef X_READ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt_r;
  logic             err_r;

  assign timeout_s = (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

  // WAIT-cycle counter; held at zero outside WAIT so every entry starts fresh
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= '0;
    end else if ((state_r == WAIT) && !bus.mem_finish) begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1);
    end else begin
      wait_cnt_r <= '0;
    end
  end

  // Timeout flag: raised with the timed-out DONE, held until the next accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if ((state_r == IDLE) && start) begin
      err_r <= 1'b0;
    end else if ((state_r == WAIT) && !bus.mem_finish && timeout_s) begin
      err_r <= 1'b1;
    end
  end

  assign err = err_r;
`else
  assign timeout_s = 1'b0;
  assign err       = 1'b0;
`endif

  // Control FSM with all handshake and status outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      index_r     <= '0;
      out_data_r  <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      mem_read_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r    <= REQ;
            busy_r     <= 1'b1;
            mem_read_r <= 1'b1;
          end
        end
        // finish from x_mem is sticky, so a stale flag must not be trusted here
        REQ: begin
          state_r <= WAIT;
        end
        WAIT: begin
          if (bus.mem_finish) begin
            state_r     <= STREAM;
            mem_read_r  <= 1'b0;
            out_valid_r <= 1'b1;
            index_r     <= '0;
            out_data_r  <= bus.mem_data[0];
            out_last_r  <= is_last(index_t'(0));
          end else if (timeout_s) begin
            state_r    <= DONE;
            mem_read_r <= 1'b0;
            done_r     <= 1'b1;
          end
        end
        STREAM: begin
          if (bus.out_ready) begin
            if (out_last_r) begin
              state_r     <= DONE;
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
              done_r      <= 1'b1;
            end else begin
              index_r    <= idx_inc_s;
              out_data_r <= next_elem_s;
              out_last_r <= is_last(idx_inc_s);
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r     <= IDLE;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
          mem_read_r  <= 1'b0;
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_r;
  assign done          = done_r;
  assign bus.mem_read  = mem_read_r;
  assign bus.mem_write = 1'b0;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_index = index_r;
  assign bus.out_last  = out_last_r;

endmodule

// File: tb/tb_x_vec_reader.sv
// Self-checking bench for x_vec_reader: vector table, random ops, reset/hold/timeout sequences.
module tb_x_vec_reader;
  import x_mem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic done;
  logic err;

  x_vec_reader_if bus();

  vector_t mem_v;
  int      rd_cnt = 0;
  int      fin_delay;
  logic    fin_force;
  logic    fin_never;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // x_mem model: finish rises fin_delay cycles into the read, or is forced sticky
  assign bus.mem_data   = mem_v;
  assign bus.mem_finish = fin_force | (~fin_never & bus.mem_read & (rd_cnt >= fin_delay));

  always @(posedge clk) rd_cnt <= bus.mem_read ? rd_cnt + 1 : 0;

`ifdef X_READ_TIMEOUT_EN
  x_vec_reader #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err), .bus(bus)
  );
`else
  x_vec_reader dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err), .bus(bus)
  );
`endif

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  function automatic logic [5:0] status();
    return {busy, done, err, bus.mem_read, bus.mem_write, bus.out_valid};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full read checked cycle by cycle against a timeline derived from the block's rules:
  // capture edge = max(finish cycle, first WAIT edge); beat n carries element n of the
  // pre-start memory image; done follows the 64th acceptance by one cycle.
  task automatic run_op(input int d, input bit sticky, input int rmode, input bit hold,
                        input bit rand_data, output int rd_cycles, output int first_edge,
                        output int beats);
    vector_t    snap;
    int         cap;
    int         last_edge;
    bit         done_seen;
    logic [5:0] exp_st;
    for (int i = 0; i < X_MEM_HEIGHT; i++)
      mem_v[i] = rand_data ? element_t'($urandom) : element_t'(32'h1000_0000 + i);
    snap       = mem_v;
    fin_delay  = d;
    fin_force  = sticky;
    fin_never  = 1'b0;
    cap        = sticky ? 2 : ((d + 1 > 2) ? d + 1 : 2);
    rd_cycles  = 0;
    first_edge = -1;
    beats      = 0;
    last_edge  = -1;
    done_seen  = 1'b0;
    start         = 1'b1;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      step();
      if (!hold) start = 1'b0;
      if (done_seen) begin
        chk("idle_after_done", status(), 6'b000000);
        break;
      end
      exp_st = {1'b1, (beats == X_MEM_HEIGHT) && (k == last_edge), 1'b0, (k < cap), 1'b0,
                (k >= cap) && (beats < X_MEM_HEIGHT)};
      chk("status", status(), exp_st);
      if (bus.mem_read) rd_cycles++;
      if (first_edge < 0 && bus.out_valid) first_edge = k;
      if (exp_st[0]) begin
        chk("out_index", bus.out_index, beats);
        chk("out_data", bus.out_data, snap[beats]);
        chk("out_last", bus.out_last, beats == X_MEM_HEIGHT - 1);
        for (int i = 0; i < X_MEM_HEIGHT; i++) mem_v[i] = element_t'($urandom);
      end
      if (exp_st[4]) done_seen = 1'b1;
      case (rmode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (k % 3 == 0);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      if (exp_st[0] && bus.out_ready) begin
        beats++;
        if (beats == X_MEM_HEIGHT) last_edge = k + 1;
      end
    end
    chk("op_completed", done_seen, 1'b1);
    bus.out_ready = 1'b0;
    fin_force     = 1'b0;
  endtask

  typedef struct {
    int d;
    bit sticky;
    int rmode;
    int exp_rd;
    int exp_first;
  } vec_t;

  vec_t tbl[7];
  int   rd, fe, bt, cap, done_edge, nvalid;

  initial begin
    rst = 1'b1; start = 1'b0; bus.out_ready = 1'b0;
    fin_force = 1'b0; fin_never = 1'b0; fin_delay = 3; mem_v = '0;

    tbl[0] = '{3, 1'b0, 0, 4, 4};
    tbl[1] = '{3, 1'b0, 1, 4, 4};
    tbl[2] = '{0, 1'b1, 0, 2, 2};
    tbl[3] = '{0, 1'b0, 2, 2, 2};
    tbl[4] = '{1, 1'b0, 1, 2, 2};
    tbl[5] = '{2, 1'b0, 2, 3, 3};
    tbl[6] = '{5, 1'b0, 0, 6, 6};

    step(); step();
    chk("reset_status", status(), 6'b000000);
    chk("reset_index", bus.out_index, 0);
    chk("reset_data", bus.out_data, 0);
    chk("reset_last", bus.out_last, 0);
    rst = 1'b0;
    step();

    foreach (tbl[i]) begin
      run_op(tbl[i].d, tbl[i].sticky, tbl[i].rmode, 1'b0, 1'b0, rd, fe, bt);
      chk("tbl_mem_read_cycles", rd, tbl[i].exp_rd);
      chk("tbl_first_beat_edge", fe, tbl[i].exp_first);
      chk("tbl_beats", bt, X_MEM_HEIGHT);
    end

    for (int n = 0; n < 4; n++) begin
      int  d;
      bit  s;
      d   = $urandom_range(0, 6);
      s   = 1'($urandom_range(0, 1));
      cap = s ? 2 : ((d + 1 > 2) ? d + 1 : 2);
      run_op(d, s, 2, 1'b0, 1'b1, rd, fe, bt);
      chk("rnd_mem_read_cycles", rd, cap);
      chk("rnd_first_beat_edge", fe, cap);
    end

    // Reset while beat 20 is on the bus, then a fresh read from index 0.
    for (int i = 0; i < X_MEM_HEIGHT; i++) mem_v[i] = element_t'(32'h1000_0000 + i);
    fin_delay = 3; start = 1'b1; bus.out_ready = 1'b1;
    for (int k = 0; k <= 24; k++) begin
      step();
      start = 1'b0;
    end
    chk("pre_rst_index", bus.out_index, 20);
    chk("pre_rst_data", bus.out_data, 32'h1000_0014);
    rst = 1'b1;
    step();
    chk("rst_mid_status", status(), 6'b000000);
    rst = 1'b0; bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post_rst_idle", status(), 6'b000000);
    end
    run_op(3, 1'b0, 0, 1'b0, 1'b0, rd, fe, bt);
    chk("post_rst_beats", bt, X_MEM_HEIGHT);

    // start held high: one operation, next one only after returning to IDLE.
    run_op(3, 1'b0, 0, 1'b1, 1'b1, rd, fe, bt);
    step();
    chk("hold_restart", status(), 6'b100100);
    start = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    step();

    fin_never = 1'b1; start = 1'b1; done_edge = -1; nvalid = 0;
`ifdef X_READ_TIMEOUT_EN
    for (int k = 0; k < 40; k++) begin
      step();
      start = 1'b0;
      if (bus.out_valid) nvalid++;
      if (done && done_edge < 0) begin
        done_edge = k;
        chk("timeout_err", err, 1'b1);
      end
    end
    chk("timeout_done_edge", done_edge, 17);
    chk("timeout_beats", nvalid, 0);
    chk("timeout_err_held", status(), 6'b001000);
    fin_never = 1'b0;
    run_op(2, 1'b0, 0, 1'b0, 1'b0, rd, fe, bt);
    chk("after_timeout_beats", bt, X_MEM_HEIGHT);
`else
    for (int k = 0; k < 40; k++) begin
      step();
      start = 1'b0;
      if (bus.out_valid || done) nvalid++;
    end
    chk("no_timeout_status", status(), 6'b100100);
    chk("no_timeout_beats", nvalid, 0);
    rst = 1'b1;
    step();
    rst = 1'b0; fin_never = 1'b0;
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/x_vec_reader.md
Name: x_vec_reader

Overview:
- Read-side initiator for the solution-vector memory (x_mem).
- Drives the memory's read strobe and waits for its finish flag.
- Captures the flattened HEIGHT x WIDTH vector in one cycle.
- Streams the elements one per beat, index 0 first, over a valid/ready handshake to the downstream update/compare datapath.

Parameters:
X_MEM_HEIGHT, 64, number of vector elements
ELEMENT_WIDTH, 32, bits per element
TIMEOUT_CYCLES, 1024, WAIT-state limit (used only with X_READ_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  request one full-vector read; sampled in IDLE only
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of operation
mem_read  out  1  to x_mem readMem
mem_write  out  1  to x_mem writeMem; constant 0
mem_finish  in  1  from x_mem finish
mem_data  in  ELEMENT_WIDTH*X_MEM_HEIGHT  flattened vector; element i at [ELEMENT_WIDTH*i +: ELEMENT_WIDTH]
out_valid  out  1  element beat valid
out_ready  in  1  downstream accepts
out_data  out  ELEMENT_WIDTH  current element
out_index  out  $clog2(X_MEM_HEIGHT)  current element index
out_last  out  1  high with index X_MEM_HEIGHT-1
err  out  1  timeout flag, valid with done

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, port rst.
- Reset values: all outputs 0, state IDLE, index 0. The shadow register is not cleared.
- Reset mid-operation: the next edge returns the block to IDLE and drops mem_read and out_valid. No done pulse is issued.
- IDLE: when start=1, go to REQ. start is ignored in every other state.
- REQ (exactly 1 cycle):
  - mem_read=1.
  - mem_finish is ignored here, because finish from x_mem is sticky.
  - Go to WAIT.
- WAIT:
  - mem_read=1.
  - On the first edge with mem_finish=1, load the shadow register from mem_data, set index=0 and go to STREAM.
  - mem_read drops in the same edge.
- STREAM:
  - out_valid=1.
  - out_data = shadow[index]; out_index = index; out_last = (index==X_MEM_HEIGHT-1).
  - While out_valid=1 && out_ready=0, out_data, out_index and out_last hold stable.
  - On out_valid && out_ready: if out_last, go to DONE; otherwise index+1.
  - Throughput is one beat per cycle when out_ready is held high.
- DONE (1 cycle): done=1, busy=1, out_valid=0. Then IDLE. A start sampled in the next IDLE cycle begins a new read.
- Latency with out_ready held high: start accepted at edge 0; mem_read high from cycle 1; capture at the first edge of WAIT with finish; first beat visible in the following cycle; last beat at capture+X_MEM_HEIGHT; done one cycle later.
- Index width is $clog2(X_MEM_HEIGHT). The index never wraps; leaving STREAM on out_last prevents it.
- The captured vector is frozen. Changes on mem_data during STREAM have no effect.

Optional Feature:
- Macro X_READ_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT and clears on entry.
  - If it reaches TIMEOUT_CYCLES without mem_finish, go to DONE with err=1 and emit no beats.
  - err clears on the next start and on rst.
- Undefined: WAIT blocks indefinitely, err is tied 0 and no counter logic is present.

Decomposition:
- Shared package x_mem_pkg:
  - X_MEM_HEIGHT and ELEMENT_WIDTH constants, also used by x_mem.
  - Element typedef logic [ELEMENT_WIDTH-1:0].
  - Index typedef.
  - State enum {IDLE, REQ, WAIT, STREAM, DONE}.
- One natural sub-module, x_vec_shadow:
  - Wide capture register with load enable.
  - Indexed element-select mux (part-select by index).
  - The FSM stays in x_vec_reader.

Test Plan:
- Memory model loaded with element i = 32'h1000_0000+i; mem_finish rises 3 cycles after mem_read; out_ready=1 → 64 beats on consecutive cycles, out_data[k]=32'h1000_0000+k, out_last only at index 63, done one cycle after the beat with index 63, mem_write always 0.
- Same stimulus with out_ready toggling 1,0,0,1... → no beat lost or duplicated; out_data and out_index stable while stalled; sequence 0..63 intact.
- mem_finish already 1 when start pulses (sticky flag) → mem_read high for ≥2 cycles; capture happens on the first WAIT edge, not in REQ.
- rst=1 for 1 cycle at beat index 20 → next cycle out_valid=0, busy=0, mem_read=0, no done. A fresh start then streams from index 0.
- start held high through the whole operation → exactly one operation; a second operation begins only after DONE returns the block to IDLE.
- X_READ_TIMEOUT_EN, TIMEOUT_CYCLES=16, mem_finish never asserted → done with err=1 sixteen cycles after entering WAIT, zero beats. Build without the macro → busy stays 1 and err=0.
